// File: rtl/ec_pkg.sv
// Shared constants and types for the elliptic-curve
// point sequencer and its micro-op ROM.
package ec_pkg;

    localparam int SIZE = 32;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [3:0] R_X1  = 4'd0;
    localparam logic [3:0] R_Y1  = 4'd1;
    localparam logic [3:0] R_X2  = 4'd2;
    localparam logic [3:0] R_Y2  = 4'd3;
    localparam logic [3:0] R_A   = 4'd4;
    localparam logic [3:0] R_T0  = 4'd5;
    localparam logic [3:0] R_T1  = 4'd6;
    localparam logic [3:0] R_T2  = 4'd7;
    localparam logic [3:0] R_LAM = 4'd8;
    localparam logic [3:0] R_X3  = 4'd9;
    localparam logic [3:0] R_Y3  = 4'd10;

    localparam logic [3:0] PC_DBL = 4'd0;
    localparam logic [3:0] PC_ADD = 4'd6;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] src0;
        logic [3:0] src1;
        logic [3:0] dst;
        logic [3:0] next_pc;
        logic       last;
    } uop_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_t;

    function automatic uop_t mk_uop(
        input logic [1:0] op,
        input logic [3:0] s0,
        input logic [3:0] s1,
        input logic [3:0] d,
        input logic [3:0] n,
        input logic       l
    );
        uop_t u;
        u.op      = op;
        u.src0    = s0;
        u.src1    = s1;
        u.dst     = d;
        u.next_pc = n;
        u.last    = l;
        return u;
    endfunction

endpackage

// File: rtl/ec_point_seq_rom.sv
// Micro-op program: doubling lambda (0-5), addition
// lambda (6-8) and the shared x3/y3 tail (9-14).
module ec_uop_rom
    import ec_pkg::*;
(
    input  logic [3:0] pc,
    output uop_t       uop
);

    // Combinational pc -> micro-op lookup
    always_comb begin
        uop = mk_uop(OP_ADD, R_X1, R_X1, R_T0, 4'd0, 1'b1);
        case (pc)
            4'd0:  uop = mk_uop(OP_MUL, R_X1, R_X1, R_T0, 4'd1, 1'b0);
            4'd1:  uop = mk_uop(OP_ADD, R_T0, R_T0, R_T1, 4'd2, 1'b0);
            4'd2:  uop = mk_uop(OP_ADD, R_T1, R_T0, R_T1, 4'd3, 1'b0);
            4'd3:  uop = mk_uop(OP_ADD, R_T1, R_A, R_T1, 4'd4, 1'b0);
            4'd4:  uop = mk_uop(OP_ADD, R_Y1, R_Y1, R_T2, 4'd5, 1'b0);
            4'd5:  uop = mk_uop(OP_DIV, R_T1, R_T2, R_LAM, 4'd9, 1'b0);
            4'd6:  uop = mk_uop(OP_SUB, R_Y2, R_Y1, R_T1, 4'd7, 1'b0);
            4'd7:  uop = mk_uop(OP_SUB, R_X2, R_X1, R_T2, 4'd8, 1'b0);
            4'd8:  uop = mk_uop(OP_DIV, R_T1, R_T2, R_LAM, 4'd9, 1'b0);
            4'd9:  uop = mk_uop(OP_MUL, R_LAM, R_LAM, R_T0, 4'd10, 1'b0);
            4'd10: uop = mk_uop(OP_SUB, R_T0, R_X1, R_T0, 4'd11, 1'b0);
            4'd11: uop = mk_uop(OP_SUB, R_T0, R_X2, R_X3, 4'd12, 1'b0);
            4'd12: uop = mk_uop(OP_SUB, R_X1, R_X3, R_T0, 4'd13, 1'b0);
            4'd13: uop = mk_uop(OP_MUL, R_LAM, R_T0, R_T0, 4'd14, 1'b0);
            4'd14: uop = mk_uop(OP_SUB, R_T0, R_Y1, R_Y3, 4'd0, 1'b1);
            default: ;
        endcase
    end

endmodule

// File: rtl/ec_point_seq.sv
// Affine point add/double sequencer driving a GF(p)
// arithmetic unit one micro-op at a time.
module ec_point_seq
    import ec_pkg::*;
#(
    parameter int SIZE    = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [SIZE-1:0] i_x1,
    input  logic [SIZE-1:0] i_y1,
    input  logic            i_inf1,
    input  logic [SIZE-1:0] i_x2,
    input  logic [SIZE-1:0] i_y2,
    input  logic            i_inf2,
    input  logic [SIZE-1:0] i_a,
    input  logic [SIZE-1:0] i_prime,
    output logic            o_busy,
    output logic            o_done,
    output logic [SIZE-1:0] o_x3,
    output logic [SIZE-1:0] o_y3,
    output logic            o_inf3,
    output logic            o_err,
    output logic [SIZE-1:0] o_gf_in_0,
    output logic [SIZE-1:0] o_gf_in_1,
    output logic [SIZE-1:0] o_gf_prime,
    output logic [1:0]      o_gf_op,
    output logic            o_gf_start,
    input  logic [SIZE-1:0] i_gf_result,
    input  logic            i_gf_done
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT);

    state_t          state;
    logic [3:0]      pc;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] rf [16];
    logic [SIZE-1:0] prime;
    logic            inf1_q;
    logic            inf2_q;
    logic            res_inf;
    logic            active;
    logic            bad;
    uop_t            uop;

    ec_uop_rom u_rom (
        .pc  (pc),
        .uop (uop)
    );

    // Operands decode only from pc and the register file,
    // so they stay frozen for the whole wait.
    assign active     = (state == S_ISSUE) || (state == S_WAIT);
    assign o_gf_in_0  = active ? rf[uop.src0] : '0;
    assign o_gf_in_1  = active ? rf[uop.src1] : '0;
    assign o_gf_op    = active ? uop.op : OP_ADD;
    assign o_gf_start = (state == S_ISSUE);
    assign o_gf_prime = prime;
    assign bad        = res_inf | o_err;

    // Sequencer: latch, classify, run micro-ops, publish R
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            cnt     <= '0;
            prime   <= '0;
            inf1_q  <= 1'b0;
            inf2_q  <= 1'b0;
            res_inf <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_x3    <= '0;
            o_y3    <= '0;
            o_inf3  <= 1'b0;
            o_err   <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        rf[R_X1] <= i_x1;
                        rf[R_Y1] <= i_y1;
                        rf[R_X2] <= i_x2;
                        rf[R_Y2] <= i_y2;
                        rf[R_A]  <= i_a;
                        prime    <= i_prime;
                        inf1_q   <= i_inf1;
                        inf2_q   <= i_inf2;
                        o_err    <= 1'b0;
                        o_busy   <= 1'b1;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    res_inf <= 1'b0;
                    state   <= S_FIN;
                    if (inf1_q) begin
                        rf[R_X3] <= rf[R_X2];
                        rf[R_Y3] <= rf[R_Y2];
                        res_inf  <= inf2_q;
                    end else if (inf2_q) begin
                        rf[R_X3] <= rf[R_X1];
                        rf[R_Y3] <= rf[R_Y1];
                    end else if (rf[R_X1] != rf[R_X2]) begin
                        pc    <= PC_ADD;
                        state <= S_ISSUE;
                    end else if (rf[R_Y1] != rf[R_Y2] ||
                                 rf[R_Y1] == '0) begin
                        res_inf <= 1'b1;
                    end else begin
                        pc    <= PC_DBL;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_gf_done) begin
                        rf[uop.dst] <= i_gf_result;
                        if (uop.last) begin
                            state <= S_FIN;
                        end else begin
                            pc    <= uop.next_pc;
                            state <= S_ISSUE;
                        end
                    end else if (cnt == TO_LAST) begin
                        o_err <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FIN: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    o_inf3 <= bad;
                    o_x3   <= bad ? '0 : rf[R_X3];
                    o_y3   <= bad ? '0 : rf[R_Y3];
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ec_point_seq.md
Name: ec_point_seq

Overview:
- Elliptic-curve point-operation sequencer; sits directly upstream of the GF(p) arithmetic unit (add/sub/mult/div, op codes 0/1/2/3).
- Computes R = P + Q in affine coordinates on y^2 = x^3 + a·x + b over GF(p), selecting doubling when P == Q.
- Issues one field micro-op at a time to the arithmetic unit via a start/done handshake and stores results in a local register file.
- Handles point-at-infinity cases without issuing any field op.

Parameters:
- SIZE, 32, field element width (matches the arithmetic unit).
- TIMEOUT, 1023, maximum cycles to wait for one micro-op's done before flagging an error.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-low
- i_start  in  1  start pulse; sampled only in IDLE
- i_x1, i_y1  in  SIZE  point P
- i_inf1  in  1  P is the point at infinity
- i_x2, i_y2  in  SIZE  point Q
- i_inf2  in  1  Q is the point at infinity
- i_a  in  SIZE  curve coefficient a
- i_prime  in  SIZE  field modulus p
- o_busy  out  1  high from the cycle after start until o_done
- o_done  out  1  one-cycle pulse; R outputs valid in the same cycle and held until the next start
- o_x3, o_y3  out  SIZE  result R
- o_inf3  out  1  R is the point at infinity
- o_err  out  1  micro-op timeout; sticky until the next start
- o_gf_in_0, o_gf_in_1  out  SIZE  operands to the arithmetic unit
- o_gf_prime  out  SIZE  latched p
- o_gf_op  out  2  0 add, 1 sub, 2 mult, 3 div (in_0/in_1)
- o_gf_start  out  1  one-cycle op start (arithmetic unit's done_from_control)
- i_gf_result  in  SIZE  arithmetic unit result
- i_gf_done  in  1  arithmetic unit done pulse; result valid in the same cycle

Behaviour:
- Reset: all outputs 0, FSM in IDLE, register file cleared. Reset mid-operation aborts immediately; o_gf_start is 0 from reset onward.
- Register file (4-bit index): X1, Y1, X2, Y2, A, T0, T1, T2, LAM, X3, Y3. On i_start in IDLE, latch all inputs and p; clear o_err.
- FSM: IDLE -> CHECK -> {FIN | ISSUE}; ISSUE -> WAIT; WAIT -> ISSUE (more uops) or FIN; FIN -> IDLE.
- CHECK decisions, in priority order:
  - inf1: R = Q.
  - inf2: R = P.
  - X1 == X2 and Y1 != Y2: R = infinity.
  - X1 == X2 and Y1 == Y2 and Y1 == 0: R = infinity.
  - X1 == X2 and Y1 == Y2 (Y1 != 0): doubling, pc = 0.
  - otherwise: addition, pc = 6.
  - All special cases go directly to FIN.
- Micro-op ROM (dst = src0 op src1):
  - Doubling lambda:
    - 0: T0 = X1*X1
    - 1: T1 = T0+T0
    - 2: T1 = T1+T0
    - 3: T1 = T1+A
    - 4: T2 = Y1+Y1
    - 5: LAM = T1/T2, then next pc = 9
  - Addition lambda:
    - 6: T1 = Y2-Y1
    - 7: T2 = X2-X1
    - 8: LAM = T1/T2
  - Common tail:
    - 9: T0 = LAM*LAM
    - 10: T0 = T0-X1
    - 11: X3 = T0-X2
    - 12: T0 = X1-X3
    - 13: T0 = LAM*T0
    - 14: Y3 = T0-Y1, last
- ISSUE (1 cycle): drive operands and op, assert o_gf_start for exactly this cycle.
- WAIT:
  - o_gf_in_0, o_gf_in_1 and o_gf_op stay stable until i_gf_done, because the multiplier reads operand bits every cycle.
  - On i_gf_done, write i_gf_result to dst and advance pc. The next ISSUE is at the earliest the following cycle.
  - i_gf_done outside WAIT is ignored.
- Timeout: a counter runs in WAIT. If it reaches TIMEOUT without done, set o_err, go to FIN, and output o_inf3 = 1.
- FIN (1 cycle): load o_x3/o_y3/o_inf3 (X3/Y3/0 on normal completion), pulse o_done, drop o_busy.
- i_start while busy: ignored. Simultaneous i_start and FIN: ignored; a start is accepted only in IDLE.
- Micro-op counts: doubling 12 o_gf_start pulses, addition 9, special cases 0.
- Latency: special case completes 3 cycles after start (o_done). Normal path is 2 + Σ(1 + op latency) cycles.

Decomposition:
- Shared package ec_pkg holds:
  - SIZE
  - GF op codes (ADD=0, SUB=1, MUL=2, DIV=3)
  - register-file index constants
  - uop record type {op[1:0], src0[3:0], src1[3:0], dst[3:0], next_pc[3:0], last}
  - FSM state enum
- One sub-module ec_uop_rom: combinational 15-entry pc -> uop lookup.

Test Plan:
- Bench uses an exact modular GFAU model with 3-cycle latency.
- p=17, a=2, P=Q=(5,1) -> doubling, 12 starts, o_done with (6,3), o_inf3=0.
- p=17, a=2, P=(5,1), Q=(6,3) -> addition, 9 starts, R=(10,6).
- P=(5,1), Q=(5,16) -> R infinity (o_inf3=1), 0 starts, o_done 3 cycles after start.
- inf1=1, Q=(6,3) -> R=(6,3); also P=(3,0) doubled -> infinity.
- Model mult latency 40 with operand-stability check; assert i_start mid-op; assert reset mid-WAIT -> operands held throughout, extra start ignored, outputs and o_gf_start return to 0 on reset.
- Model never returns done -> o_err=1 after TIMEOUT cycles, o_done pulse, o_inf3=1; next start clears o_err.
